// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the radix-4 Booth multiplier.
//   - FSM state encoding (IDLE/BUSY/END)
//   - operand, extended-operand and iteration-count widths
//   - Booth digit encoding and the window-to-digit decode helper
package mul_pkg;

  localparam int kMulOpWidth  = 32;
  localparam int kMulExtWidth = 34;
  localparam int kMulIters    = 17;

  // acc carries two guard bits above the 34-bit extended operand so that
  // adding or subtracting 2A can never overflow.
  localparam int kMulAccWidth = kMulExtWidth + 2;
  // {acc, mplr, lookahead}
  localparam int kMulDpWidth  = kMulAccWidth + kMulExtWidth + 1;
  localparam int kMulCntWidth = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_END  = 2'd2
  } mul_state_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = BOOTH_POS1;
      3'b011:         d = BOOTH_POS2;
      3'b100:         d = BOOTH_NEG2;
      3'b101, 3'b110: d = BOOTH_NEG1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// booth_r4_sel: combinational radix-4 Booth partial-product selector.
// Ports:
//   i_win     in  3   Booth window {mplr[1:0], lookahead}
//   i_mcand   in  36  extended multiplicand
//   o_addend  out 36  magnitude to add: 0, A or 2A
//   o_sub     out 1   1 = subtract o_addend from the accumulator
module booth_r4_sel
  import mul_pkg::*;
(
  input  logic [2:0]              i_win,
  input  logic [kMulAccWidth-1:0] i_mcand,
  output logic [kMulAccWidth-1:0] o_addend,
  output logic                    o_sub
);

  booth_digit_t w_digit;

  always_comb begin
    w_digit  = booth_decode(i_win);
    o_addend = '0;
    o_sub    = 1'b0;
    case (w_digit)
      BOOTH_POS1: o_addend = i_mcand;
      BOOTH_POS2: o_addend = {i_mcand[kMulAccWidth-2:0], 1'b0};
      BOOTH_NEG1: begin
        o_addend = i_mcand;
        o_sub    = 1'b1;
      end
      BOOTH_NEG2: begin
        o_addend = {i_mcand[kMulAccWidth-2:0], 1'b0};
        o_sub    = 1'b1;
      end
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/multiplier16t_r4.sv
// multiplier16t_r4: iterative 32x32->64 radix-4 Booth multiplier with a
// start/done handshake (MULT / MULTU).
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous active-high reset
//   en         in  1   start request, sampled in IDLE only
//   signed_op  in  1   1 = two's-complement operands, sampled with en
//   op_a       in  32  multiplicand, sampled with en
//   op_b       in  32  multiplier (Booth-recoded), sampled with en
//   result_hi  out 32  product[63:32]
//   result_lo  out 32  product[31:0]
//   busy       out 1   high from the accept edge until the return to IDLE
//   done       out 1   one-cycle completion pulse
// Build option: MUL_EARLY_OUT_EN ends the iteration as soon as the
// remaining Booth digits are all zero.
//
// state | meaning
// IDLE  | waiting for en; drops done
// BUSY  | one Booth digit per cycle (counter 0..16)
// END   | publish product, pulse done, drop busy
module multiplier16t_r4
  import mul_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   signed_op,
  input  logic [kMulOpWidth-1:0] op_a,
  input  logic [kMulOpWidth-1:0] op_b,
  output logic [kMulOpWidth-1:0] result_hi,
  output logic [kMulOpWidth-1:0] result_lo,
  output logic                   busy,
  output logic                   done
);

  mul_state_t                r_state;
  logic [kMulCntWidth-1:0]   r_cnt;
  logic [kMulAccWidth-1:0]   r_mcand;
  logic [kMulAccWidth-1:0]   r_acc;
  logic [kMulExtWidth-1:0]   r_mplr;
  logic                      r_la;

  logic [kMulAccWidth-1:0]   w_addend;
  logic                      w_sub;
  logic [kMulAccWidth-1:0]   w_sum;
  logic [kMulDpWidth-1:0]    w_dp_sum;
  logic [kMulDpWidth-1:0]    w_dp_next;
  logic [kMulDpWidth-1:0]    w_dp_load;
  logic                      w_last;
  logic                      w_go_end;

  booth_r4_sel u_sel (
    .i_win    ({r_mplr[1:0], r_la}),
    .i_mcand  (r_mcand),
    .o_addend (w_addend),
    .o_sub    (w_sub)
  );

  assign w_sum     = w_sub ? (r_acc - w_addend) : (r_acc + w_addend);
  assign w_dp_sum  = {w_sum, r_mplr, r_la};
  // Arithmetic shift right by one digit; acc sign fills the top.
  assign w_dp_next = {{2{w_sum[kMulAccWidth-1]}}, w_dp_sum[kMulDpWidth-1:2]};
  assign w_last    = (r_cnt == kMulCntWidth'(kMulIters - 1));

`ifdef MUL_EARLY_OUT_EN
  logic [kMulCntWidth-1:0] w_iters_done;
  logic [5:0]              w_used_bits;
  logic [5:0]              w_rem_bits;
  logic [kMulExtWidth:0]   w_tail;
  logic [kMulExtWidth:0]   w_mask;
  logic                    w_tail_uniform;

  // After j digits the unconsumed multiplier bits plus the lookahead sit in
  // the low (35 - 2j) bits of {mplr, la}. If they all agree, every remaining
  // digit decodes to zero, so the rest of the run is pure shifting and can be
  // collapsed into one barrel shift.
  assign w_iters_done   = r_cnt + kMulCntWidth'(1);
  assign w_used_bits    = {w_iters_done, 1'b0};
  assign w_rem_bits     = 6'(2 * kMulIters) - w_used_bits;
  assign w_tail         = w_dp_next[kMulExtWidth:0];
  assign w_mask         = {(kMulExtWidth + 1){1'b1}} >> w_used_bits;
  assign w_tail_uniform = ((w_tail & w_mask) == '0) || ((w_tail & w_mask) == w_mask);
  assign w_go_end       = w_last || w_tail_uniform;
  assign w_dp_load      = $signed(w_dp_next) >>> w_rem_bits;
`else
  assign w_go_end  = w_last;
  assign w_dp_load = w_dp_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplr    <= '0;
      r_la      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (en) begin
            r_mcand <= {{(kMulAccWidth - kMulOpWidth){signed_op & op_a[kMulOpWidth-1]}}, op_a};
            r_mplr  <= {{(kMulExtWidth - kMulOpWidth){signed_op & op_b[kMulOpWidth-1]}}, op_b};
            r_acc   <= '0;
            r_la    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          {r_acc, r_mplr, r_la} <= w_dp_load;
          r_cnt <= r_cnt + kMulCntWidth'(1);
          if (w_go_end) r_state <= ST_END;
        end
        ST_END: begin
          // {acc, mplr} holds the 68-bit product; keep the low 64 bits.
          result_hi <= {r_acc[kMulOpWidth-3:0], r_mplr[kMulExtWidth-1:kMulOpWidth]};
          result_lo <= r_mplr[kMulOpWidth-1:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier16t_r4.sv
module tb_multiplier16t_r4;

`ifdef MUL_EARLY_OUT_EN
  localparam bit kEarly = 1'b1;
`else
  localparam bit kEarly = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multiplier16t_r4 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint pa, pb;
    pa = s ? {{32{a[31]}}, a} : {32'd0, a};
    pb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return pa * pb;
  endfunction

  // Cycles from accept to done. With early-out, the run ends after the
  // first digit j where every bit of the 34-bit extended multiplier from
  // bit 2j-1 upward is identical (remaining digits are all zero).
  function automatic int ref_lat(input logic [31:0] b, input logic s);
    logic [33:0] be, t, mask;
    int lat;
    lat = 18;
    be  = {{2{s & b[31]}}, b};
    if (kEarly) begin
      for (int j = 17; j >= 1; j--) begin
        t    = be >> (2 * j - 1);
        mask = {34{1'b1}} >> (2 * j - 1);
        if (t == '0 || t == mask) lat = j + 1;
      end
    end
    return lat;
  endfunction

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (en) begin
        m_busy <= 1'b1;
        m_left <= ref_lat(op_b, signed_op);
        m_pend <= ref_prod(op_a, op_b, signed_op);
      end
    end else if (m_left == 1) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_hi   <= m_pend[63:32];
      m_lo   <= m_pend[31:0];
    end else begin
      m_left <= m_left - 1;
    end
  end

  task automatic cyc_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL cyc_%s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cyc_check("busy", {31'd0, busy}, {31'd0, m_busy});
      cyc_check("done", {31'd0, done}, {31'd0, m_done});
      cyc_check("hi", result_hi, m_hi);
      cyc_check("lo", result_lo, m_lo);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where
  // done is seen. lat counts rising edges from accept to done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat);
    op_a      = a;
    op_b      = b;
    signed_op = s;
    en        = 1'b1;
    @(negedge clk);
    en        = 1'b0;
    op_a      = ~a;
    op_b      = ~b;
    signed_op = ~s;
    lat       = 0;
    while (done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_op_timeout: got no done expected done within 64 cycles");
    end
    hi = result_hi;
    lo = result_lo;
  endtask

  function automatic logic [31:0] bb_a(input int i);
    return 32'(i + 2);
  endfunction

  function automatic logic [31:0] bb_b(input int i);
    return 32'(i + 5);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [31:0] hi, lo;
    int          lat;
    bit          saw_done;
    int          nd;
    int          d_idx [2];
    logic [63:0] d_prod [2];
    int          acc2;
    int          w;

    rst = 1'b1; en = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'd0, result_hi}, 64'd0);
    check("rst_lo", {32'd0, result_lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, hi, lo, lat);
    check("umax_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("umax_lo", {32'd0, lo}, 64'h1);
    check("umax_lat", 64'(lat), 64'd18);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, hi, lo, lat);
    check("sneg1_hi", {32'd0, hi}, 64'h0);
    check("sneg1_lo", {32'd0, lo}, 64'h1);
    check("sneg1_lat", 64'(lat), 64'(kEarly ? 2 : 18));

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, hi, lo, lat);
    check("smin_hi", {32'd0, hi}, 64'h4000_0000);
    check("smin_lo", {32'd0, lo}, 64'h0);
    check("smin_lat", 64'(lat), 64'(kEarly ? 17 : 18));

    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, hi, lo, lat);
    check("mix_s_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mix_s_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    check("mix_s_lat", 64'(lat), 64'(kEarly ? 3 : 18));

    run_op(32'hFFFF_FFFD, 32'd7, 1'b0, hi, lo, lat);
    check("mix_u_hi", {32'd0, hi}, 64'h6);
    check("mix_u_lo", {32'd0, lo}, 64'hFFFF_FFEB);

    run_op(32'd5, 32'd0, 1'b0, hi, lo, lat);
    check("zero_prod", {hi, lo}, 64'h0);
    check("zero_lat", 64'(lat), 64'(kEarly ? 2 : 18));

    run_op(32'd5, 32'd3, 1'b0, hi, lo, lat);
    check("five3_lo", {hi, lo}, 64'hF);
    check("five3_lat", 64'(lat), 64'(kEarly ? 3 : 18));

    run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, hi, lo, lat);
    check("x1_prod", {hi, lo}, ref_prod(32'hDEAD_BEEF, 32'h1234_5678, 1'b0));
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, hi, lo, lat);
    check("x2_prod", {hi, lo}, ref_prod(32'h7FFF_FFFF, 32'h8000_0000, 1'b1));
    run_op(32'd12345, 32'hFFFF_FD5A, 1'b1, hi, lo, lat);
    check("x3_prod", {hi, lo}, ref_prod(32'd12345, 32'hFFFF_FD5A, 1'b1));

    // Reset while busy: accept at E0, rst sampled at E5.
    op_a = 32'd7; op_b = 32'd9; signed_op = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done === 1'b1) saw_done = 1'b1;
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_res", {result_hi, result_lo}, 64'd0);
    rst = 1'b0;
    run_op(32'd5, 32'd3, 1'b0, hi, lo, lat);
    check("post_abort_lo", {hi, lo}, 64'hF);

    // en held high, operands changing every cycle.
    signed_op = 1'b0;
    en   = 1'b1;
    op_a = bb_a(0);
    op_b = bb_b(0);
    nd   = 0;
    d_idx  = '{-1, -1};
    d_prod = '{64'd0, 64'd0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 && nd < 2) begin
        d_idx[nd]  = i;
        d_prod[nd] = {result_hi, result_lo};
        nd++;
      end
      op_a = bb_a(i + 1);
      op_b = bb_b(i + 1);
    end
    en = 1'b0;
    // Default build: done after E18 and E37, products 2*5=10 and 21*24=504.
    acc2 = ref_lat(bb_b(0), 1'b0) + 1;
    check("b2b_count", 64'(nd), 64'd2);
    check("b2b_idx0", 64'(d_idx[0]), 64'(ref_lat(bb_b(0), 1'b0)));
    check("b2b_idx1", 64'(d_idx[1]), 64'(acc2 + ref_lat(bb_b(acc2), 1'b0)));
    check("b2b_prod0", d_prod[0], ref_prod(bb_a(0), bb_b(0), 1'b0));
    check("b2b_prod1", d_prod[1], ref_prod(bb_a(acc2), bb_b(acc2), 1'b0));

    w = 0;
    while (busy !== 1'b0 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got busy=1 expected busy=0 within 64 cycles");
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
